// File: rtl/io_uart_tx.sv
// IO-bus responder for the RV32 SOC: LED register, TX byte FIFO and an 8N1 UART transmitter.
// Register selects are one-hot on word address bits [4:2]; reads are combinational.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic        uart_tx,
  output logic [5:0]  leds
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic sel_leds, sel_dat, sel_ctrl;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          push_req, push, pop;
  logic          overflow;

  tx_state_t     state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [7:0]    shreg, shreg_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic          tx_next, baud_zero, tx_idle;

  logic [31:0] count_wide;
  logic [4:0]  count_field;
  logic [31:0] ctrl_word;
  logic        unused_bits;

  assign sel_leds = IO_mem_addr[2];
  assign sel_dat  = IO_mem_addr[3];
  assign sel_ctrl = IO_mem_addr[4];

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = IO_mem_wr & sel_dat;
  assign push       = push_req & ~fifo_full;
  assign baud_zero  = (baud == '0);
  assign tx_idle    = fifo_empty & (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= '0;
    end else if (IO_mem_wr && sel_leds) begin
      leds <= IO_mem_wdata[5:0];
    end
  end

  // Full is judged on the pre-edge count, so a push while full is lost even if a pop frees a slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && fifo_full)
        overflow <= 1'b1;
      else if (IO_mem_wr && sel_ctrl && IO_mem_wdata[10])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= IO_mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      uart_tx <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (baud_zero) state_next = DATA;
      DATA:    if (baud_zero && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (baud_zero) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // The line value is computed one cycle ahead so uart_tx itself is a flop.
  always_comb begin
    pop          = 1'b0;
    baud_next    = baud_zero ? baud : baud - 1'b1;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    tx_next      = uart_tx;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = fifo_mem[rd_ptr];
          baud_next  = BAUD_MAX;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_zero) begin
          tx_next      = shreg[0];
          bit_idx_next = '0;
          baud_next    = BAUD_MAX;
        end
      end
      DATA: begin
        if (baud_zero) begin
          baud_next = BAUD_MAX;
          if (bit_idx == 3'd7) begin
            tx_next = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            shreg_next   = {1'b0, shreg[7:1]};
            tx_next      = shreg[1];
          end
        end
      end
      STOP: begin
        if (baud_zero) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shreg_next = fifo_mem[rd_ptr];
            baud_next  = BAUD_MAX;
            tx_next    = 1'b0;
          end else begin
            tx_next = 1'b1;
          end
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  // Count field saturates at 16 so deeper FIFOs still fit the 5-bit field.
  assign count_wide  = 32'(count);
  assign count_field = (count_wide > 32'd16) ? 5'd16 : count_wide[4:0];
  assign ctrl_word   = {21'b0, overflow, fifo_full, tx_idle, 3'b0, count_field};

  assign IO_mem_rdata = (sel_leds ? {26'b0, leds} : 32'b0) |
                        (sel_ctrl ? ctrl_word     : 32'b0);

  assign unused_bits = ^{IO_mem_addr[31:16], IO_mem_addr[15:5], IO_mem_addr[1:0],
                         IO_mem_wdata[31:11], IO_mem_wdata[9:8], count_wide[31:5]};

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=16.
// Serial frames are checked cycle by cycle against a start/data/stop model built from the byte.
module tb_io_uart_tx;

  localparam int CPB = 4;
  localparam logic [31:0] A_NONE  = 32'h0040_0000;
  localparam logic [31:0] A_LEDS  = 32'h0040_0004;
  localparam logic [31:0] A_DAT   = 32'h0040_0008;
  localparam logic [31:0] A_LD    = 32'h0040_000C;
  localparam logic [31:0] A_CTRL  = 32'h0040_0010;
  localparam logic [31:0] A_LC    = 32'h0040_0014;
  localparam logic [31:0] A_OTHER = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;
  logic        uart_tx;
  logic [5:0]  leds;

  int checks = 0;
  int errors = 0;

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .IO_mem_addr  (IO_mem_addr),
    .IO_mem_wdata (IO_mem_wdata),
    .IO_mem_wr    (IO_mem_wr),
    .IO_mem_rdata (IO_mem_rdata),
    .uart_tx      (uart_tx),
    .leds         (leds)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One write pulse; the targeted edge is the next rising edge, returns 1 time unit after it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    IO_mem_addr  = addr;
    IO_mem_wdata = data;
    IO_mem_wr    = 1'b1;
    @(posedge clk);
    #1;
    IO_mem_wr    = 1'b0;
    IO_mem_addr  = 32'h0;
    IO_mem_wdata = 32'h0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    IO_mem_addr = addr;
    #1;
    data = IO_mem_rdata;
    IO_mem_addr = 32'h0;
  endtask

  // Checks one full frame starting at the next edge; optionally reads CTRL during data bit 1.
  task automatic checkFrame(input logic [7:0] b, input logic ctrlAtEight);
    logic [7:0]  decoded;
    logic        exp;
    logic [31:0] rd;
    int          bitNo;
    decoded = 8'h00;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(posedge clk);
      #1;
      bitNo = k / CPB;
      if (bitNo == 0)      exp = 1'b0;
      else if (bitNo == 9) exp = 1'b1;
      else                 exp = b[bitNo-1];
      checkOutput("frame_bit", {31'b0, uart_tx}, {31'b0, exp});
      if (bitNo >= 1 && bitNo <= 8 && (k % CPB) == CPB / 2)
        decoded[bitNo-1] = uart_tx;
      if (ctrlAtEight && k == 8) begin
        readReg(A_CTRL, rd);
        checkOutput("ctrl_mid_frame", rd, 32'h0);
      end
    end
    checkOutput("decoded_byte", {24'b0, decoded}, {24'b0, b});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          lows;
    bit          drained;

    reset        = 1'b1;
    IO_mem_addr  = 32'h0;
    IO_mem_wdata = 32'h0;
    IO_mem_wr    = 1'b0;
    #1;
    checkOutput("tx_during_reset", {31'b0, uart_tx}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    readReg(A_CTRL, rd);
    checkOutput("ctrl_after_reset", rd, 32'h0000_0100);
    checkOutput("tx_after_reset", {31'b0, uart_tx}, 32'h1);
    checkOutput("leds_after_reset", {26'b0, leds}, 32'h0);

    // LED register and decode corners
    applyStimulus(A_LEDS, 32'h0000_003F);
    readReg(A_LEDS, rd);
    checkOutput("leds_read_3f", rd, 32'h0000_003F);
    applyStimulus(A_LEDS, 32'hFFFF_FFC5);
    checkOutput("leds_pins_05", {26'b0, leds}, 32'h0000_0005);
    readReg(A_DAT, rd);
    checkOutput("dat_reads_zero", rd, 32'h0);
    readReg(A_NONE, rd);
    checkOutput("no_select_zero", rd, 32'h0);
    readReg(A_OTHER, rd);
    checkOutput("ignored_bit_zero", rd, 32'h0);

    // Single byte 0x55
    applyStimulus(A_DAT, 32'h0000_0055);
    checkFrame(8'h55, 1'b1);
    @(posedge clk);
    #1;
    readReg(A_CTRL, rd);
    checkOutput("ctrl_idle_after_55", rd, 32'h0000_0100);

    // Back-to-back frames with no idle gap
    fork
      begin
        applyStimulus(A_DAT, 32'h41);
        applyStimulus(A_DAT, 32'h42);
        applyStimulus(A_DAT, 32'h43);
      end
      begin
        @(posedge clk);
        checkFrame(8'h41, 1'b0);
        checkFrame(8'h42, 1'b0);
        checkFrame(8'h43, 1'b0);
      end
    join
    @(posedge clk);
    #1;
    readReg(A_CTRL, rd);
    checkOutput("ctrl_idle_after_b2b", rd, 32'h0000_0100);

    // Multi-select write hits both LEDS and UART_DAT
    applyStimulus(A_LD, 32'h0000_002A);
    checkOutput("multi_leds", {26'b0, leds}, 32'h0000_002A);
    readReg(A_LC, rd);
    checkOutput("multi_read_busy", rd, 32'h0000_002B);
    checkFrame(8'h2A, 1'b0);
    @(posedge clk);
    #1;
    readReg(A_LC, rd);
    checkOutput("multi_read_idle", rd, 32'h0000_012A);

    // Overflow: 18 writes, 17 accepted
    for (int i = 0; i < 18; i++)
      applyStimulus(A_DAT, 32'(i + 8'h30));
    readReg(A_CTRL, rd);
    checkOutput("ctrl_overflow", rd, 32'h0000_0610);
    applyStimulus(A_CTRL, 32'h0000_0400);
    readReg(A_CTRL, rd);
    checkOutput("ctrl_overflow_cleared", rd, 32'h0000_0210);
    drained = 1'b0;
    for (int c = 0; c < 1000 && !drained; c++) begin
      @(posedge clk);
      #1;
      readReg(A_CTRL, rd);
      if (rd == 32'h0000_0100) drained = 1'b1;
    end
    checkOutput("drain_idle", rd, 32'h0000_0100);

    // Reset in the middle of data bit 3 of 0x00 with another byte queued
    applyStimulus(A_DAT, 32'h0000_0000);
    applyStimulus(A_DAT, 32'h0000_007E);
    repeat (17) @(posedge clk);
    #1;
    checkOutput("mid_frame_low", {31'b0, uart_tx}, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_tx", {31'b0, uart_tx}, 32'h1);
    checkOutput("async_reset_leds", {26'b0, leds}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    readReg(A_CTRL, rd);
    checkOutput("ctrl_after_mid_reset", rd, 32'h0000_0100);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (uart_tx !== 1'b1) lows++;
    end
    checkOutput("no_frame_after_reset", 32'(lows), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped IO responder for the RV32 core's IO bus. It holds the LED output register, a byte FIFO, and an 8N1 UART transmitter. It decodes one-hot IO word addresses, accepts single-cycle write pulses from the core's memory stage, and returns combinational read data that the core samples in the same cycle. It sits in the SOC between the core's IO port and the board pins.

## Interface
- CLKS_PER_BIT, default 234 — clock cycles per UART bit; must be ≥2.
- FIFO_DEPTH, default 16 — TX FIFO entries; power of two, ≥2.

- clk  in  1  — system clock; all state changes on its rising edge.
- reset  in  1  — asynchronous, active-high reset.
- IO_mem_addr  in  32  — byte address; only [15:2] is decoded, [1:0] and [31:16] are ignored.
- IO_mem_wdata  in  32  — write data.
- IO_mem_wr  in  1  — write strobe, one cycle per store, sampled on the rising edge.
- IO_mem_rdata  out  32  — combinational read data.
- uart_tx  out  1  — serial line, registered, idles high.
- leds  out  6  — LED register.

## Operation
- Word address is w = IO_mem_addr[15:2], one-hot select:
  - w[0] selects LEDS (0x400004).
  - w[1] selects UART_DAT (0x400008).
  - w[2] selects UART_CTRL (0x400010).
  - All other bits of w are ignored.
- A write with several select bits set applies to every selected register. A read returns the OR of every selected register; no selects gives 0.
- Reads have no side effects and there is no read strobe.
- LEDS:
  - Write latches wdata[5:0].
  - Read returns {26'b0, leds}.
- UART_DAT:
  - Write pushes wdata[7:0] into the FIFO.
  - Read returns 0.
- UART_CTRL read format:
  - [4:0] FIFO count, saturating at 16 for wider depths.
  - [8] idle: FIFO empty and FSM in IDLE.
  - [9] FIFO full.
  - [10] overflow, sticky.
  - All other bits 0.
- UART_CTRL write: wdata[10]=1 clears overflow. All other bits are ignored.
- FIFO full/push rule: "full" is evaluated on the pre-edge count. A push while full is dropped and sets overflow, even if a pop happens in the same cycle.
- TX FSM states are IDLE, START, DATA, STOP. A down-counter `baud` of width $clog2(CLKS_PER_BIT) times each bit.
  - IDLE: if the FIFO is non-empty, pop into `shreg`, set baud=CLKS_PER_BIT-1, drive uart_tx=0, and go to START.
  - START: when baud==0, drive shreg[0], set bit index 0, and go to DATA.
  - DATA: when baud==0, shift the LSB-first bit out. After bit 7 completes, drive 1 and go to STOP.
  - STOP: when baud==0, if the FIFO is non-empty, pop and go directly to START (drive 0). Otherwise go to IDLE.
  - Every bit lasts exactly CLKS_PER_BIT cycles. A frame is 10·CLKS_PER_BIT cycles.
- Reset:
  - Takes effect immediately and asynchronously.
  - State after reset: uart_tx=1, leds=0, FIFO empty, overflow=0, FSM=IDLE.
  - A frame in progress is truncated: the line goes high at once.
  - After reset, a UART_CTRL read returns 0x00000100.

## Timing
- Write at edge E0 into an empty FIFO with the FSM idle:
  - The count becomes 1 after E0.
  - The FSM pops at E1, and uart_tx=0 from E1.
  - The stop bit ends at E1+10·CLKS_PER_BIT.
  - idle reads 1 from that edge onward if nothing else is queued.
- Back-to-back frames have no idle gap: the next start bit begins exactly at the edge ending the previous stop bit.
- A push and a pop in the same edge give a net count change of 0.
- IO_mem_rdata is valid in the same cycle as the address. Register updates from a write are visible to a read on the next cycle.

## Test plan
- Reset: pulse reset, then read 0x400010 → 0x00000100. Check uart_tx=1 and leds=0.
- Single byte, CLKS_PER_BIT=4: write 0x55 to 0x400008 at E0.
  - uart_tx is 0 for cycles E1..E1+3, then data 1,0,1,0,1,0,1,0 for 4 cycles each, then stop 1 for 4 cycles.
  - CTRL reads 0 at E1+8 and 0x100 from E1+40.
- Back-to-back: write 0x41, 0x42, 0x43 on consecutive cycles.
  - Expect 30 continuous bit times over 120 cycles with no high gap between stop and start.
  - Decoded bytes are 0x41, 0x42, 0x43.
- Overflow, depth 16: 18 writes on consecutive cycles from idle.
  - The first 17 are accepted (byte 0 is popped at E1). The 18th is dropped.
  - CTRL reads 0x610 (count 16, full, overflow).
  - Writing 0x400 to 0x400010 clears overflow, giving 0x210.
- Multi-select: write 0x2A to 0x40000C.
  - leds=0x2A and byte 0x2A is transmitted.
  - Reading 0x400014 returns 0x2A OR the CTRL value.
- Reset mid-frame: assert reset during data bit 3.
  - uart_tx goes 1 in the same cycle (asynchronously).
  - After release, CTRL reads 0x100 and no further frame is sent.
